// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package clk_div_pkg;

  localparam int MIN_DIV = 2;

  typedef enum logic {
    DIV_TOGGLE = 1'b0,
    DIV_PULSE  = 1'b1
  } div_mode_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } chan_state_e;

endpackage

// File: rtl/clk_div_multi_if.sv
// Ratio/mode write port of the clock divider: one strobe, one-cycle ack/err reply.
interface clk_div_multi_if #(
  parameter int CH = 4,
  parameter int DW = 16
);
  localparam int SW = (CH > 1) ? $clog2(CH) : 1;

  logic          div_wr;
  logic [SW-1:0] div_sel;
  logic [DW-1:0] div_val;
  logic          div_mode;
  logic          div_ack;
  logic          div_err;

  modport master (output div_wr, div_sel, div_val, div_mode, input div_ack, div_err);
  modport slave  (input div_wr, div_sel, div_val, div_mode, output div_ack, div_err);
endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, run/stop FSM and boundary-applied shadow ratio.
//   state    | meaning
//   IDLE     | stopped, cnt = 0, outputs low; shadow applies on any edge
//   RUN      | counting periods while en is high
//   STOPPING | en dropped; finish current period, then IDLE
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DW      = 16,
  parameter int RST_DIV = 4
) (
  input  logic          I_CLK,
  input  logic          rst_n,
  input  logic          en,
  input  logic          wr,
  input  logic [DW-1:0] wr_val,
  input  div_mode_e     wr_mode,
  output logic          clk,
  output logic          tick,
  output logic          busy
);

  localparam int W1 = DW + 1;

  chan_state_e   state, state_n;
  logic [DW-1:0] cnt, cnt_n;
  logic [DW-1:0] ratio, ratio_n, shadow_val;
  div_mode_e     mode, mode_n, shadow_mode;
  logic          pending;
  logic          boundary;
  logic          tick_n, clk_n;
  logic [DW:0]   half_n;

  always_comb begin
    boundary = (state == IDLE) || tick;
    ratio_n  = (boundary && pending) ? shadow_val  : ratio;
    mode_n   = (boundary && pending) ? shadow_mode : mode;

    if (state == IDLE)
      state_n = en ? RUN : IDLE;
    else if (tick)
      state_n = en ? RUN : IDLE;
    else
      state_n = en ? RUN : STOPPING;

    if (state_n == IDLE || boundary)
      cnt_n = '0;
    else
      cnt_n = cnt + DW'(1);

    // Computed one bit wider so D = 2^DW-1 does not wrap.
    half_n = ({1'b0, ratio_n} + W1'(1)) >> 1;
    tick_n = (state_n != IDLE) && (cnt_n == ratio_n - DW'(1));
    if (state_n == IDLE)
      clk_n = 1'b0;
    else if (mode_n == DIV_PULSE)
      clk_n = tick_n;
    else
      clk_n = ({1'b0, cnt_n} < half_n);
  end

  always_ff @(posedge I_CLK or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      ratio       <= DW'(RST_DIV);
      mode        <= DIV_TOGGLE;
      shadow_val  <= DW'(RST_DIV);
      shadow_mode <= DIV_TOGGLE;
      pending     <= 1'b0;
      clk         <= 1'b0;
      tick        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ratio <= ratio_n;
      mode  <= mode_n;
      clk   <= clk_n;
      tick  <= tick_n;
      busy  <= (state_n != IDLE);
      // A write on a boundary edge stays pending; the old shadow is what applies.
      if (wr) begin
        shadow_val  <= wr_val;
        shadow_mode <= wr_mode;
        pending     <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: write decode, ack/err, CH channel instances.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int CH      = 4,
  parameter int DW      = 16,
  parameter int RST_DIV = 4
) (
  input  logic            I_CLK,
  input  logic            rst_n,
  input  logic [CH-1:0]   en,
  clk_div_multi_if.slave  bus,
  output logic [CH-1:0]   O_CLK,
  output logic [CH-1:0]   O_TICK,
  output logic [CH-1:0]   O_BUSY
);

  localparam int SW = (CH > 1) ? $clog2(CH) : 1;

  logic [CH-1:0] hit;
  logic          val_ok;
  logic          wr_ok;

  always_comb begin
    hit = '0;
    for (int i = 0; i < CH; i++)
      hit[i] = (bus.div_sel == SW'(i));
  end

  assign val_ok = (bus.div_val >= DW'(MIN_DIV));
  assign wr_ok  = bus.div_wr && val_ok && (|hit);

  always_ff @(posedge I_CLK or negedge rst_n) begin
    if (!rst_n) begin
      bus.div_ack <= 1'b0;
      bus.div_err <= 1'b0;
    end else begin
      bus.div_ack <= wr_ok;
      bus.div_err <= bus.div_wr && !wr_ok;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_chan
    clk_div_chan #(
      .DW      (DW),
      .RST_DIV (RST_DIV)
    ) u_chan (
      .I_CLK   (I_CLK),
      .rst_n   (rst_n),
      .en      (en[g]),
      .wr      (wr_ok && hit[g]),
      .wr_val  (bus.div_val),
      .wr_mode (div_mode_e'(bus.div_mode)),
      .clk     (O_CLK[g]),
      .tick    (O_TICK[g]),
      .busy    (O_BUSY[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: expected lengths queued with stimulus, popped on measurement.
module tb_clk_div_multi;
  import clk_div_pkg::*;

  localparam int CH = 4;
  localparam int DW = 16;
  localparam int RST_DIV = 4;

  logic          I_CLK = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] en = '0;
  logic [CH-1:0] O_CLK, O_TICK, O_BUSY;

  clk_div_multi_if #(.CH(CH), .DW(DW)) bus ();

  clk_div_multi #(.CH(CH), .DW(DW), .RST_DIV(RST_DIV)) dut (
    .I_CLK  (I_CLK),
    .rst_n  (rst_n),
    .en     (en),
    .bus    (bus),
    .O_CLK  (O_CLK),
    .O_TICK (O_TICK),
    .O_BUSY (O_BUSY)
  );

  always #5 I_CLK = ~I_CLK;

  typedef struct { string name; int val; } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input string n, input int v);
    exp_q.push_back('{n, v});
  endtask

  // Negedges until O_TICK[c] is seen; -1 when the bound expires.
  task automatic wait_tick(input int c, output int n);
    n = 0;
    do begin
      @(negedge I_CLK);
      n++;
    end while (!O_TICK[c] && n < 200);
    if (!O_TICK[c]) n = -1;
  endtask

  // Called in a tick cycle: high and low lengths of the following period.
  task automatic measure(input int c, output int hi, output int lo);
    hi = 0;
    @(negedge I_CLK);
    while (O_CLK[c] && hi < 200) begin
      hi++;
      @(negedge I_CLK);
    end
    lo = 1;
    while (!O_TICK[c] && lo < 200) begin
      @(negedge I_CLK);
      if (O_CLK[c]) break;
      lo++;
    end
  endtask

  task automatic do_write(input int sel, input int val, input bit mode, input int ack, input int err);
    exp_t e;
    int ob;
    push("div_ack", ack);
    push("div_err", err);
    bus.div_wr   = 1'b1;
    bus.div_sel  = 2'(sel);
    bus.div_val  = 16'(val);
    bus.div_mode = mode;
    @(negedge I_CLK);
    bus.div_wr = 1'b0;
    e = exp_q.pop_front(); ob = int'(bus.div_ack); checks++;
    if (ob !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, ob, e.val); end
    e = exp_q.pop_front(); ob = int'(bus.div_err); checks++;
    if (ob !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, ob, e.val); end
  endtask

  task automatic test_reset();
    exp_t e;
    int ob;
    push("rst_clk", 0); push("rst_tick", 0); push("rst_busy", 0); push("rst_ack", 0); push("rst_err", 0);
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: ob = int'(O_CLK);
        1: ob = int'(O_TICK);
        2: ob = int'(O_BUSY);
        3: ob = int'(bus.div_ack);
        default: ob = int'(bus.div_err);
      endcase
      e = exp_q.pop_front(); checks++;
      if (ob !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, ob, e.val); end
    end
    rst_n = 1'b1;
    push("post_rst_busy", 0);
    @(negedge I_CLK);
    e = exp_q.pop_front(); ob = int'(O_BUSY); checks++;
    if (ob !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, ob, e.val); end
  endtask

  task automatic test_reset_default();
    exp_t e;
    int n, hi, lo;
    en[0] = 1'b1;
    push("ch0_clk_start", 1); push("ch0_first_tick", 3); push("ch0_hi", 2); push("ch0_lo", 2); push("ch0_period", 4);
    @(negedge I_CLK);
    e = exp_q.pop_front(); n = int'(O_CLK[0]); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    wait_tick(0, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    measure(0, hi, lo);
    e = exp_q.pop_front(); checks++;
    if (hi !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, hi, e.val); end
    e = exp_q.pop_front(); checks++;
    if (lo !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, lo, e.val); end
    wait_tick(0, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
  endtask

  task automatic test_odd_ratio();
    exp_t e;
    int n, hi, lo;
    do_write(1, 5, 1'b0, 1, 0);
    en[1] = 1'b1;
    push("ch1_first_tick", 5); push("ch1_hi", 3); push("ch1_lo", 2); push("ch1_period", 5);
    wait_tick(1, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    measure(1, hi, lo);
    e = exp_q.pop_front(); checks++;
    if (hi !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, hi, e.val); end
    e = exp_q.pop_front(); checks++;
    if (lo !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, lo, e.val); end
    wait_tick(1, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
  endtask

  task automatic test_midrun_change();
    exp_t e;
    int n, hi, lo;
    wait_tick(0, n);
    @(negedge I_CLK);
    @(negedge I_CLK);
    do_write(0, 10, 1'b0, 1, 0);
    push("mid_cur_period_rest", 1); push("mid_hi", 5); push("mid_lo", 5); push("mid_period", 10);
    wait_tick(0, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    measure(0, hi, lo);
    e = exp_q.pop_front(); checks++;
    if (hi !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, hi, e.val); end
    e = exp_q.pop_front(); checks++;
    if (lo !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, lo, e.val); end
    wait_tick(0, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
  endtask

  task automatic test_illegal_write();
    exp_t e;
    int n, hi, lo;
    do_write(2, 1, 1'b0, 0, 1);
    en[2] = 1'b1;
    push("ch2_first_tick", RST_DIV); push("ch2_hi", 2); push("ch2_lo", 2);
    wait_tick(2, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    measure(2, hi, lo);
    en[2] = 1'b0;
    e = exp_q.pop_front(); checks++;
    if (hi !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, hi, e.val); end
    e = exp_q.pop_front(); checks++;
    if (lo !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, lo, e.val); end
  endtask

  task automatic test_graceful_stop();
    exp_t e;
    int n;
    do_write(3, 8, 1'b1, 1, 0);
    en[3] = 1'b1;
    push("ch3_pulse_clk_low", 0); push("ch3_busy_start", 1); push("ch3_first_tick", 7); push("ch3_clk_eq_tick", 1);
    push("ch3_busy_stopping", 1); push("ch3_stop_tick", 4); push("ch3_busy_after", 0); push("ch3_clk_after", 0);
    @(negedge I_CLK);
    e = exp_q.pop_front(); n = int'(O_CLK[3]); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    e = exp_q.pop_front(); n = int'(O_BUSY[3]); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    wait_tick(3, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    e = exp_q.pop_front(); n = int'(O_CLK[3]); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    repeat (3) @(negedge I_CLK);
    en[3] = 1'b0;
    @(negedge I_CLK);
    e = exp_q.pop_front(); n = int'(O_BUSY[3]); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    wait_tick(3, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    @(negedge I_CLK);
    e = exp_q.pop_front(); n = int'(O_BUSY[3]); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    e = exp_q.pop_front(); n = int'(O_CLK[3]); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end

    en[3] = 1'b1;
    push("ch3_rerun_first", 8); push("ch3_resume_tick", 2); push("ch3_resume_busy", 1); push("ch3_resume_period", 7);
    push("ch3_final_busy", 0);
    wait_tick(3, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    repeat (3) @(negedge I_CLK);
    en[3] = 1'b0;
    repeat (3) @(negedge I_CLK);
    en[3] = 1'b1;
    wait_tick(3, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    @(negedge I_CLK);
    e = exp_q.pop_front(); n = int'(O_BUSY[3]); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    wait_tick(3, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    en[3] = 1'b0;
    @(negedge I_CLK);
    e = exp_q.pop_front(); n = int'(O_BUSY[3]); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int n, hi, lo;
    wait_tick(0, n);
    @(negedge I_CLK);
    do_write(0, 6, 1'b0, 1, 0);
    do_write(0, 3, 1'b0, 1, 0);
    push("b2b_rest", 7); push("b2b_hi", 2); push("b2b_lo", 1);
    wait_tick(0, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    measure(0, hi, lo);
    e = exp_q.pop_front(); checks++;
    if (hi !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, hi, e.val); end
    e = exp_q.pop_front(); checks++;
    if (lo !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, lo, e.val); end
    do_write(0, 5, 1'b0, 1, 0);
    push("bnd_write_old_period", 2); push("bnd_write_new_period", 5);
    wait_tick(0, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    wait_tick(0, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
  endtask

  task automatic test_async_reset();
    exp_t e;
    int n, hi, lo;
    wait_tick(0, n);
    @(negedge I_CLK);
    #2 rst_n = 1'b0;
    push("arst_clk", 0); push("arst_tick", 0); push("arst_busy", 0);
    #1;
    e = exp_q.pop_front(); n = int'(O_CLK); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    e = exp_q.pop_front(); n = int'(O_TICK); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    e = exp_q.pop_front(); n = int'(O_BUSY); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    en = '0;
    @(negedge I_CLK);
    rst_n = 1'b1;
    en = '1;
    push("arst_first_tick", RST_DIV); push("arst_all_tick", 15); push("arst_ch3_hi", 2); push("arst_ch3_lo", 2);
    wait_tick(0, n);
    e = exp_q.pop_front(); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    e = exp_q.pop_front(); n = int'(O_TICK); checks++;
    if (n !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, n, e.val); end
    measure(3, hi, lo);
    en = '0;
    e = exp_q.pop_front(); checks++;
    if (hi !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, hi, e.val); end
    e = exp_q.pop_front(); checks++;
    if (lo !== e.val) begin errors++; $display("FAIL %s: observed %0d, required %0d", e.name, lo, e.val); end
  endtask

  initial begin
    bus.div_wr   = 1'b0;
    bus.div_sel  = '0;
    bus.div_val  = '0;
    bus.div_mode = 1'b0;
    repeat (3) @(negedge I_CLK);
    test_reset();
    test_reset_default();
    test_odd_ratio();
    test_midrun_change();
    test_illegal_write();
    test_graceful_stop();
    test_back_to_back();
    test_async_reset();
    repeat (3) @(negedge I_CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Parametrised multi-channel programmable clock divider, the successor to the single fixed-ratio `Divider`. It derives CH independent divided clock/strobe outputs from `I_CLK`. Each channel has a runtime-programmable ratio and duty mode, and applies ratio changes only at period boundaries so the output never glitches. Each channel also stops gracefully at the end of its current period. The block sits at the top of the design's clocking tree and feeds display scanning, debouncers and slow-logic enables.

## Interface
- `CH`, 4: number of output channels (1..16).
- `DW`, 16: divide-ratio width in bits.
- `RST_DIV`, 4: divide ratio loaded into every channel at reset (≥2).
- `I_CLK` input 1: system clock; all logic is on its rising edge.
- `rst_n` input 1: one clock; reset is asynchronous and active-low.
- `en` input CH: per-channel run request.
- `div_wr` input 1: single-cycle write strobe for the ratio/mode shadow.
- `div_sel` input $clog2(CH) (min 1): target channel of the write.
- `div_val` input DW: new divide ratio D.
- `div_mode` input 1: 0 = toggle (≈50 % duty), 1 = pulse (one-cycle high).
- `div_ack` output 1: one-cycle pulse, the cycle after an accepted write.
- `div_err` output 1: one-cycle pulse, the cycle after a rejected write.
- `O_CLK` output CH: divided clock (toggle mode) or strobe (pulse mode), registered.
- `O_TICK` output CH: one-cycle pulse in the last cycle of every period.
- `O_BUSY` output CH: channel running.

## Operation
- Reset values: `O_CLK`, `O_TICK`, `O_BUSY`, `div_ack` and `div_err` are all 0. Every channel has ratio `RST_DIV`, mode 0 and counter 0, with no pending update.
- Per-channel counter `cnt` runs 0..D-1.
  - Toggle mode: `O_CLK` is high for cnt < ceil(D/2) and low otherwise. High lasts ceil(D/2) cycles, low lasts floor(D/2).
  - Pulse mode: `O_CLK` equals `O_TICK`.
- Per-channel states:
  - IDLE → RUN when `en` is sampled 1.
  - RUN → STOPPING when `en` is sampled 0.
  - STOPPING → RUN when `en` is sampled 1 again before the period ends. The counter is not restarted.
  - STOPPING → IDLE after the `O_TICK` cycle of the current period.
- In IDLE, `cnt` is 0 and all channel outputs are 0. `O_BUSY` is 1 in RUN and STOPPING.
- Writes:
  - D < 2 sets `div_err` and is discarded.
  - Otherwise `div_val`/`div_mode` go to a shadow register for `div_sel`, a pending flag is set, and `div_ack` pulses.
- Shadow apply:
  - IDLE channel: applied on the next edge.
  - Running channel: applied on the edge that ends an `O_TICK` cycle, so the new period starts at cnt = 0.
- A second write to the same channel while an update is pending overwrites the shadow (last write wins).
- A write that coincides with a boundary edge becomes the pending update. The boundary applies the previous shadow, if one exists.
- Ratio arithmetic: unsigned DW bits. ceil(D/2) = (D+1)>>1, computed at DW+1 bits with no overflow. D = 2^DW-1 is legal.

## Timing
- Write latency: `div_wr` sampled at edge k → `div_ack` or `div_err` high during cycle k..k+1.
- Start latency: `en` sampled 1 at edge e0 →
  - `O_CLK` rises after e0 (toggle mode) or after e0+D-1 (pulse mode).
  - The first `O_TICK` is high in cycle e0+D-1..e0+D, then repeats every D cycles.
- Stop: the last `O_TICK` pulse completes, then all channel outputs read 0 from the next edge. A period is never truncated.
- `rst_n` asserted mid-operation clears all outputs immediately (asynchronous). Pending writes are lost.
- Deassertion of `rst_n` must be synchronised to `I_CLK` upstream.
- Channels are fully independent. Simultaneous writes are impossible by construction (one write port).

## Structure
- Package `clk_div_pkg` holds:
  - the mode enum `DIV_TOGGLE`/`DIV_PULSE`;
  - the channel state enum `IDLE`/`RUN`/`STOPPING`;
  - `MIN_DIV = 2`.
- Sub-module `clk_div_chan` is one channel: counter, FSM, shadow and apply logic. `clk_div_multi` instantiates it CH times through a generate loop and holds the write decode and ack/err registers.

## Test plan
- Reset default: hold `en[0]` = 1 after reset, toggle mode, ratio 4 → `O_CLK[0]` is 2 cycles high / 2 low, and `O_TICK[0]` pulses every 4 cycles.
- Odd ratio: write ch1 D = 5, mode 0, then enable → `div_ack` pulses. `O_CLK[1]` is 3 high / 2 low, with period 5 on consecutive `O_TICK` pulses.
- Mid-run change: ch0 running D = 4, write D = 10 at cnt = 1 → the current period still lasts 4 cycles, the next period is 10 cycles (5/5), and there is no output glitch.
- Illegal write: write D = 1 to ch2 → `div_err` pulses, `div_ack` stays 0, and the ch2 ratio is unchanged.
- Graceful stop: pulse mode, D = 8, drop `en` at cnt = 2 → `O_TICK` still fires at cnt = 7, then `O_BUSY` drops. A second run, with `en` re-raised at cnt = 5, continues without a restart.
- Async reset: assert `rst_n` = 0 mid-high phase → all outputs are 0 immediately. After release, every channel restarts from `RST_DIV`.
